// File: rtl/fastmont_pkg.sv
// Shared constants for the FASTMONT datapath: adder width, adder latency and
// requester id encodings used on the shared-adder arbiter.
package fastmont_pkg;
  localparam int   ADD_N    = 1027;
  localparam int   ADD_LAT  = 1;
  localparam logic REQ_MONT = 1'b0;
  localparam logic REQ_RED  = 1'b1;
endpackage

// File: rtl/mpadder_arbiter_if.sv
// Request/response bus between the two FASTMONT requesters and the adder arbiter.
// Requester i occupies index [i] of the packed operand arrays.
interface mpadder_arbiter_if
  import fastmont_pkg::*;
#(
  parameter int N = ADD_N
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][N-1:0] req_a;
  logic [1:0][N-1:0] req_b;
  logic [1:0]        req_shift;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [N:0]        rsp_data;

  modport master (
    output req_valid, req_a, req_b, req_shift, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_shift, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/mpadder_rsp_fifo.sv
// Circular response FIFO with occupancy output; head is read combinationally
// and stays put until popped.
module mpadder_rsp_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 3,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          head_valid,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    do_pop;

  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];
  assign do_pop     = pop & head_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (do_pop)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Upstream credit accounting guarantees a slot for every result in flight.
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(push && count == CW'(DEPTH)));
endmodule

// File: rtl/mpadder_arbiter.sv
// Round-robin arbiter sharing one pipelined adder between the Montgomery loop
// and the reduction path; results return in order, tagged with requester id.
module mpadder_arbiter
  import fastmont_pkg::*;
#(
  parameter int N         = ADD_N,
  parameter int RSP_DEPTH = 3
) (
  input  logic             clk,
  input  logic             resetn,
  mpadder_arbiter_if.slave bus,
  output logic [N-1:0]     add_a,
  output logic [N-1:0]     add_b,
  output logic             add_leftshift,
  input  logic [N:0]       add_result
);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic       id;
    logic [N:0] data;
  } rsp_t;

  // vld_pipe[0] = operand regs (S0), vld_pipe[ADD_LAT] = adder output stage
  logic [ADD_LAT:0] vld_pipe, id_pipe;
  logic             rr_last;
  logic [1:0]       ready, grant;
  logic             accept, win_id, credit_ok;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      inflight;
  rsp_t             push_entry, head;
  logic             head_valid, pop;

  // Every op in the adder pipe already owns a FIFO slot; pops free a slot next cycle.
  always_comb begin
    inflight = {1'b0, fifo_count};
    for (int i = 0; i <= ADD_LAT; i++)
      inflight = inflight + (CW+1)'(vld_pipe[i]);
  end

  assign credit_ok = resetn & (inflight < (CW+1)'(RSP_DEPTH));

  // Ready looks only at the other requester's valid, never its own.
  assign ready[REQ_MONT] = credit_ok & (~bus.req_valid[REQ_RED] | rr_last);
  assign ready[REQ_RED]  = credit_ok & (~bus.req_valid[REQ_MONT] | ~rr_last);
  assign bus.req_ready   = ready;
  assign grant           = bus.req_valid & ready;
  assign accept          = |grant;
  assign win_id          = grant[REQ_RED] ? REQ_RED : REQ_MONT;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      add_a         <= '0;
      add_b         <= '0;
      add_leftshift <= 1'b0;
      rr_last       <= 1'b1;
      vld_pipe      <= '0;
      id_pipe       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[ADD_LAT-1:0], accept};
      id_pipe  <= {id_pipe[ADD_LAT-1:0], win_id};
      if (accept) begin
        add_a         <= bus.req_a[win_id];
        add_b         <= bus.req_b[win_id];
        add_leftshift <= bus.req_shift[win_id];
        rr_last       <= win_id;
      end
    end
  end

  assign push_entry = '{id: id_pipe[ADD_LAT], data: add_result};
  assign pop        = head_valid & bus.rsp_ready;

  mpadder_rsp_fifo #(
    .W     ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (vld_pipe[ADD_LAT]),
    .push_data  (push_entry),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head),
    .count      (fifo_count)
  );

  assign bus.rsp_valid = head_valid;
  assign bus.rsp_id    = head.id;
  assign bus.rsp_data  = head.data;
endmodule

// File: tb/tb_mpadder_arbiter.sv
// Scoreboard bench for the shared-adder arbiter with a behavioural 1-cycle adder.
module tb_mpadder_arbiter;
  import fastmont_pkg::*;
  localparam int N = ADD_N;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  mpadder_arbiter_if #(.N(N)) bus ();
  logic [N-1:0] add_a, add_b;
  logic         add_leftshift;
  logic [N:0]   add_result;

  mpadder_arbiter #(.N(N), .RSP_DEPTH(3)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (bus.slave),
    .add_a         (add_a),
    .add_b         (add_b),
    .add_leftshift (add_leftshift),
    .add_result    (add_result)
  );

  typedef struct {
    logic       id;
    logic [N:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic       acc_ids[$];
  logic [N:0] exp_pend[2];
  int tests = 0, fails = 0, cyc = 0, acc_cnt = 0, pop_cnt = 0;
  int last_acc_cyc = -1, last_pop_cyc = -1, rise_cyc = -1;
  logic prev_v = 1'b0;

  function automatic logic [N:0] ref_add(logic [N-1:0] a, logic [N-1:0] b, logic sh);
    return {1'b0, a} + (sh ? {b, 1'b0} : {1'b0, b});
  endfunction

  function automatic logic [N-1:0] rand_op();
    logic [N+31:0] t;
    t = '0;
    for (int k = 0; k < N; k += 32) t[k +: 32] = $urandom;
    if ($urandom_range(7) == 0) return '1;
    return t[N-1:0];
  endfunction

  // Adder model: registered sum, valid one clock after add_* are driven.
  always @(posedge clk) add_result <= ref_add(add_a, add_b, add_leftshift);
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [N:0] act, input logic [N:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got hi=%h lo=%h, required hi=%h lo=%h", nm,
               act[N -: 32], act[63:0], exp[N -: 32], exp[63:0]);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // Accept monitor: pushes the expected response for each handshake.
  initial forever begin
    @(negedge clk);
    if (resetn) begin
      for (int i = 0; i < 2; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          exp_q.push_back('{id: 1'(i), data: exp_pend[i]});
          acc_ids.push_back(1'(i));
          acc_cnt++;
          last_acc_cyc = cyc;
        end
      if (|(bus.req_valid & bus.req_ready))
        chk_i("one_accept", int'(&(bus.req_valid & bus.req_ready)), 0);
    end
  end

  // Response monitor: pops the scoreboard on every consumed response.
  initial forever begin
    @(negedge clk);
    if (resetn && bus.rsp_valid && !prev_v) rise_cyc = cyc;
    prev_v = resetn && bus.rsp_valid;
    if (resetn && bus.rsp_valid && bus.rsp_ready) begin
      pop_cnt++;
      last_pop_cyc = cyc;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rsp: got id=%0d data lo=%h, required no response",
                 bus.rsp_id, bus.rsp_data[63:0]);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_id", N'(bus.rsp_id), N'(e.id));
        chk("rsp_data", bus.rsp_data, e.data);
      end
    end
  end

  task automatic drive_one(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic sh, input logic [N:0] e);
    bit ok;
    @(posedge clk); #1;
    bus.req_a[id] = a;
    bus.req_b[id] = b;
    bus.req_shift[id] = sh;
    exp_pend[id] = e;
    bus.req_valid[id] = 1'b1;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.req_ready[id]) ok = 1;
    end
    chk_i("accept_timeout", int'(ok), 1);
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    chk_i("drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    bus.req_valid = '0;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    chk_i("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk_i("rst_req_ready", int'(bus.req_ready), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] pw, ones;
    logic [N:0]   e1, e2;
    int a0, p0;
    bit ok;

    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_shift = '0;
    bus.rsp_ready = 1'b1;
    exp_pend[0] = '0;
    exp_pend[1] = '0;

    #1 resetn = 1'b0;
    #1;
    chk_i("reset_req_ready", int'(bus.req_ready), 0);
    chk_i("reset_rsp_valid", int'(bus.rsp_valid), 0);
    chk("reset_add_a", {1'b0, add_a}, '0);
    chk("reset_add_b", {1'b0, add_b}, '0);
    chk_i("reset_add_leftshift", int'(add_leftshift), 0);
    chk("reset_rsp_data", bus.rsp_data, '0);
    chk_i("reset_rsp_id", int'(bus.rsp_id), 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Single op and its 3-cycle latency.
    drive_one(0, N'(5), N'(7), 1'b0, (N+1)'(12));
    a0 = last_acc_cyc;
    wait_drain();
    chk_i("latency", rise_cyc - a0, 3);

    // Wide operands: leftshift path and carry-out into bit N.
    pw = '0; pw[1025] = 1'b1;
    e1 = '0; e1[1026] = 1'b1; e1[0] = 1'b1;
    ones = '1;
    e2 = '1; e2[0] = 1'b0;
    drive_one(0, N'(1), pw, 1'b1, e1);
    drive_one(0, ones, ones, 1'b0, e2);
    drive_one(1, N'(100), N'(23), 1'b0, (N+1)'(123));
    wait_drain();

    // Both requesters valid for 8 cycles: round-robin starting at 0, credit-limited.
    do_reset();
    acc_ids.delete();
    a0 = acc_cnt;
    @(posedge clk); #1;
    bus.req_a[0] = N'(10);   bus.req_b[0] = N'(20); bus.req_shift[0] = 1'b0;
    exp_pend[0] = (N+1)'(30);
    bus.req_a[1] = N'(1000); bus.req_b[1] = N'(1);  bus.req_shift[1] = 1'b1;
    exp_pend[1] = (N+1)'(1002);
    bus.req_valid = 2'b11;
    repeat (8) @(posedge clk);
    #1 bus.req_valid = '0;
    chk_i("alt_accepts", acc_cnt - a0, 6);
    for (int k = 0; k < acc_ids.size(); k++) chk_i("alt_order", int'(acc_ids[k]), k % 2);
    wait_drain();

    // Backpressure: three credits, then one pop frees exactly one accept.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_a[0] = N'(3); bus.req_b[0] = N'(4); bus.req_shift[0] = 1'b0;
    exp_pend[0] = (N+1)'(7);
    a0 = acc_cnt;
    bus.req_valid[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk_i("bp_accepts", acc_cnt - a0, 3);
    chk_i("bp_ready_low", int'(bus.req_ready[0]), 0);
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk_i("bp_one_more", acc_cnt - a0, 4);
    chk_i("bp_accept_after_pop", last_acc_cyc, last_pop_cyc + 1);
    repeat (3) @(negedge clk);
    chk_i("bp_still_stalled", acc_cnt - a0, 4);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_drain();

    // Reset with two ops in flight: both dropped.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_a[0] = N'(9); bus.req_b[0] = N'(9); bus.req_shift[0] = 1'b0;
    exp_pend[0] = (N+1)'(18);
    a0 = acc_cnt;
    bus.req_valid[0] = 1'b1;
    for (int k = 0; k < 20 && acc_cnt - a0 < 2; k++) @(negedge clk);
    @(posedge clk); #1 bus.req_valid[0] = 1'b0;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) ok = 1;
    end
    chk_i("mid_rsp_seen", int'(ok), 1);
    #1 resetn = 1'b0;
    exp_q.delete();
    #1 chk_i("mid_rsp_valid_clear", int'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    bus.rsp_ready = 1'b1;
    p0 = pop_cnt;
    repeat (10) @(negedge clk);
    chk_i("mid_no_ghost", pop_cnt - p0, 0);
    drive_one(0, N'(11), N'(22), 1'b0, (N+1)'(33));
    wait_drain();

    // Random stress against the scoreboard.
    a0 = acc_cnt;
    repeat (1500) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        bus.req_valid[i] = 1'($urandom_range(1));
        bus.req_a[i] = rand_op();
        bus.req_b[i] = rand_op();
        bus.req_shift[i] = 1'($urandom_range(1));
        exp_pend[i] = ref_add(bus.req_a[i], bus.req_b[i], bus.req_shift[i]);
      end
      bus.rsp_ready = ($urandom_range(3) != 0);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    wait_drain();
    chk_i("stress_progress", int'(acc_cnt - a0 > 300), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
